// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the EX-stage ALU and the ALU control decoder.
//   ALU_*       : 3-bit operation codes carried on ALUCtrl_i.
//   alu_state_t : sequencing state of alu_seq (IDLE accepts work, MUL iterates).
//   alu_is_mul  : true for the one operation that takes the multi-cycle path.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    function automatic logic alu_is_mul(input logic [2:0] code);
        return code == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_seq_step.sv
// mul_seq_step: one combinational step of the shift-and-add multiplier.
//   i_acc / o_acc       : running product (low WIDTH bits only).
//   i_mcand / o_mcand   : multiplicand, shifted left MUL_BPC bits per step.
//   i_mplier / o_mplier : multiplier, shifted right MUL_BPC bits per step.
// The low MUL_BPC multiplier bits select how many copies of the multiplicand
// are added this step; anything above bit WIDTH-1 is dropped, which is exact
// for the low half of the product.
module mul_seq_step #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0] o_mplier
);

    logic [WIDTH-1:0] w_digit;
    logic [WIDTH-1:0] w_partial;

    always_comb begin
        w_digit   = WIDTH'(i_mplier[MUL_BPC-1:0]);
        w_partial = i_mcand * w_digit;
        o_acc     = i_acc + w_partial;
        o_mcand   = i_mcand << MUL_BPC;
        o_mplier  = i_mplier >> MUL_BPC;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential execute-stage ALU.
//   clk_i, rst_i (async, active-high), flush_i (sync abort)
//   valid_i / ready_o : an operation issues on a rising edge when
//                       valid_i && ready_o && !flush_i. ready_o depends on
//                       state only, so there is no valid_i -> ready_o path.
//   ALUCtrl_i, data1_i (A), data2_i (B) : operation and operands.
//   data_o, zero_o : registered result, held until the next completion.
//   valid_o        : one-cycle pulse when data_o/zero_o were just written.
//   state_o        : current sequencing state, for observation.
// AND/OR/ADD/SUB (and undefined codes, which yield 0) complete in one cycle.
// MUL runs WIDTH/MUL_BPC shift-and-add steps; ready_o drops for that time.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output alu_state_t       state_o
);

    localparam int N  = WIDTH / MUL_BPC;
    localparam int CW = $clog2(N + 1);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_valid;

    logic             w_issue;
    logic             w_last_step;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mcand_next;
    logic [WIDTH-1:0] w_mplier_next;

    mul_seq_step #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_next),
        .o_mcand  (w_mcand_next),
        .o_mplier (w_mplier_next)
    );

    // Single-cycle result; undefined codes produce 0.
    always_comb begin
        w_alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND: w_alu_res = data1_i & data2_i;
            ALU_OR:  w_alu_res = data1_i | data2_i;
            ALU_ADD: w_alu_res = data1_i + data2_i;
            ALU_SUB: w_alu_res = data1_i - data2_i;
            default: w_alu_res = '0;
        endcase
    end

    // Next-state and handshake decode.
    always_comb begin
        ready_o      = (r_state == IDLE);
        w_issue      = valid_i && ready_o && !flush_i;
        w_last_step  = (r_state == MUL) && (r_cnt == CW'(1));
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_issue && alu_is_mul(ALUCtrl_i)) w_state_next = MUL;
            MUL:  if (w_last_step) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush_i) w_state_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_data   <= '0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= 1'b0;
            if (flush_i) begin
                // Abort: result registers keep their last completed value.
                r_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_issue) begin
                            if (alu_is_mul(ALUCtrl_i)) begin
                                r_mcand  <= data1_i;
                                r_mplier <= data2_i;
                                r_acc    <= '0;
                                r_cnt    <= CW'(N);
                            end else begin
                                r_data  <= w_alu_res;
                                r_zero  <= (w_alu_res == '0);
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    MUL: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= w_mcand_next;
                        r_mplier <= w_mplier_next;
                        r_cnt    <= r_cnt - CW'(1);
                        if (w_last_step) begin
                            r_data  <= w_acc_next;
                            r_zero  <= (w_acc_next == '0);
                            r_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_o  = r_data;
    assign zero_o  = r_zero;
    assign valid_o = r_valid;
    assign state_o = r_state;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential execute-stage ALU. Consumes the 3-bit ALU control code from the ALU control decoder plus two operands, performs and/or/add/sub in one cycle, and performs multiply iteratively over several cycles. A valid/ready handshake lets the pipeline stall on multiply. It sits directly downstream of the ALU control decoder in the EX stage; its registered result feeds EX/MEM.

## Interface
- `WIDTH`, 32, operand/result width.
- `MUL_BPC`, 1, multiplier bits retired per cycle; must divide WIDTH (1, 2, 4, 8).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset. Asynchronous and active-high.
- `flush_i` in 1: abort any in-flight operation. Synchronous.
- `valid_i` in 1: operation offered this cycle.
- `ready_o` out 1: block accepts an operation this cycle.
- `ALUCtrl_i` in 3: operation code.
- `data1_i` in WIDTH: operand A.
- `data2_i` in WIDTH: operand B.
- `data_o` out WIDTH: registered result. Held until the next completion.
- `zero_o` out 1: registered; 1 when the completed result equals 0.
- `valid_o` out 1: one-cycle pulse when `data_o` and `zero_o` are updated.

## Operation
- Codes:
  - 000: A & B
  - 001: A | B
  - 010: A + B
  - 110: A − B
  - 100: multiply
  - 011, 101, 111: result 0
- Add and sub are modulo 2^WIDTH. There are no overflow or carry outputs.
- Multiply returns the low WIDTH bits of A×B. These bits are identical for signed and unsigned operands, so no sign handling is needed.
- Issue condition: `valid_i && ready_o && !flush_i` at a rising edge.
- States: IDLE, MUL.
- IDLE:
  - `ready_o` = 1.
  - On issue of a non-mul code: write `data_o` and `zero_o`, pulse `valid_o`, stay in IDLE.
  - On issue of code 100: latch A into the multiplicand register and B into the multiplier register, clear the accumulator, set the step counter to N = WIDTH/MUL_BPC, go to MUL.
- MUL:
  - `ready_o` = 0. `valid_i` is ignored and nothing is captured.
  - Each edge: accumulator += multiplicand × (multiplier[MUL_BPC-1:0]); multiplicand <<= MUL_BPC; multiplier >>= MUL_BPC; counter −= 1.
  - On the edge that takes the counter from 1 to 0: write `data_o` = final accumulator, update `zero_o`, pulse `valid_o`, go to IDLE.
- `flush_i` = 1 at an edge:
  - State goes to IDLE, the counter clears, and `valid_o` = 0.
  - `data_o` and `zero_o` keep their old values.
  - No issue occurs that edge, even if `valid_i` = 1.
- Reset (asynchronous, any state):
  - State IDLE, `data_o` = 0, `zero_o` = 0, `valid_o` = 0.
  - `ready_o` = 1 once reset deasserts.
  - Accumulator, operand registers and counter clear to 0.
  - A multiply in flight is discarded.
- `valid_o` is 0 on every edge with no completion.

## Timing
- Non-mul latency: 1 cycle. Issue at edge E0; `valid_o` = 1 in the cycle after E0.
- Mul latency: N+1 cycles. Issue at E0; steps at E1..EN; `valid_o` = 1 in the cycle after EN.
  - For WIDTH=32, MUL_BPC=1: 33 cycles.
- `ready_o` is low from after E0 through EN. It rises in the same cycle `valid_o` pulses, so back-to-back issue is allowed.
- Non-mul throughput: one operation per cycle.
- `ready_o` is a function of state only. There is no combinational path from `valid_i` to `ready_o`.
- Counter width: $clog2(N+1).
- Accumulator width: WIDTH. Higher product bits are discarded each step.

## Structure
- Package `alu_pkg`, shared with the ALU control decoder:
  - ALU code constants `ALU_AND`=3'b000, `ALU_OR`=3'b001, `ALU_ADD`=3'b010, `ALU_SUB`=3'b110, `ALU_MUL`=3'b100.
  - State enum `alu_state_t` {IDLE, MUL}.
- Sub-module `mul_seq_step`: the combinational single-step datapath (accumulator update and shifts), parameterised by WIDTH and MUL_BPC.
- `alu_seq` owns the FSM, counter, handshake and output registers.

## Test plan
- Add and sub:
  - ADD A=5, B=7 → next cycle `valid_o`=1, `data_o`=12, `zero_o`=0, `ready_o` stays 1.
  - SUB A=3, B=3 → `data_o`=0, `zero_o`=1.
  - SUB A=0, B=1 → `data_o`=0xFFFFFFFF.
- Back-to-back non-mul: issue AND 0xF0F0 & 0x0FF0, then OR 0xF000 | 0x000F on consecutive cycles.
  - Expect two consecutive `valid_o` pulses with `data_o`=0x00F0, then 0xF00F.
- Multiply:
  - MUL A=0xFFFFFFFF, B=3, MUL_BPC=1 → `ready_o` low for 32 cycles, `valid_o` 33 cycles after issue, `data_o`=0xFFFFFFFD.
  - Hold `valid_i`=1 with ADD throughout → ADD issues only on the `ready_o`-high cycle, and its result appears next cycle.
  - Repeat the MUL with MUL_BPC=4 → latency 9 cycles, same result.
- Flush mid-mul: MUL 6×7, assert `flush_i` at step 10 together with `valid_i`.
  - Expect no `valid_o`, `data_o` unchanged, `ready_o`=1 the next cycle.
  - A following ADD 1+1 → 2.
- Reset mid-mul: assert `rst_i` asynchronously mid-cycle during MUL.
  - Outputs go 0 immediately and state goes IDLE.
  - After release, MUL 2×2 → 4 after 33 cycles.
- Undefined codes: 011, 101, 111 with A=B=0xFFFF → `data_o`=0, `zero_o`=1, latency 1.
